// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg : shared types, sizes and the round-robin pick helper for arb_rr4
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set request at or above ptr, wrapping modulo N_REQ. The loop runs
  // downward so the smallest offset from ptr is the last assignment and wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    idx = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) idx = cand;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_2to4.sv
// ============================================================================
// decoder_2to4 : binary index to one-hot decode
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module decoder_2to4 (
  input  logic [1:0] x,
  output logic [3:0] y
);

  assign y = 4'b0001 << x;

endmodule

`default_nettype wire

// File: rtl/arb_rr4.sv
// ============================================================================
// arb_rr4 : 4-requester round-robin arbiter with done/request-drop release.
//           Define ARB_TIMEOUT_EN to add the HOLD_MAX grant-timeout counter.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module arb_rr4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("arb_rr4: HOLD_MAX must be within 1..255");
  end

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [IDX_W-1:0] pick_idx;
  logic             release_req;
  logic             hold_expired;
  logic             leave_grant;
  logic [N_REQ-1:0] dec_y;

  assign pick_idx    = rr_pick(req, ptr_q);
  assign release_req = done | ~req[gnt_idx_q];
  assign leave_grant = release_req | hold_expired;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] c_hold_max = 8'(HOLD_MAX);

  logic [7:0] hold_cnt_q;
  logic       timeout_q;

  assign hold_expired = (hold_cnt_q >= c_hold_max);
  assign timeout      = timeout_q;

  // Counter holds the number of grant cycles already shown, so a grant is
  // visible for exactly HOLD_MAX cycles before the revoking edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        hold_cnt_q <= (|req) ? 8'd1 : 8'd0;
      end else if (leave_grant) begin
        hold_cnt_q <= 8'd0;
        timeout_q  <= ~release_req;
      end else begin
        hold_cnt_q <= hold_cnt_q + 8'd1;
      end
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_idx_q <= pick_idx;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          if (leave_grant) begin
            ptr_q   <= gnt_idx_q + IDX_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = gnt_idx_q;

  decoder_2to4 u_dec (
    .x (gnt_idx_q),
    .y (dec_y)
  );

  assign gnt = dec_y & {N_REQ{gnt_valid}};

endmodule

`default_nettype wire

// File: tb/tb_arb_rr4.sv
// ============================================================================
// tb_arb_rr4 : directed and random checks of arb_rr4 against a queue-free
//              owner/pointer model of the round-robin rules.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_arb_rr4;

  localparam int TB_HOLD = 3;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = 4'b0;
  logic       done  = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  arb_rr4 #(.HOLD_MAX(TB_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: who owns the grant (-1 = nobody), where the next search starts,
  // the last grantee, how many grant cycles have elapsed, timeout pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_last  = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    bit rel;
    bit tmo;
    bit found;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_hold++;
      rel = d || !r[m_owner];
      tmo = TO_EN && (m_hold >= TB_HOLD) && !rel;
      if (rel || tmo) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_to    = tmo;
      end
    end else if (r != 4'b0) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          found   = 1'b1;
        end
      end
      m_last = m_owner;
      m_hold = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    check_value({tag, ".gnt"},       32'(gnt),       32'(exp_gnt));
    check_value({tag, ".gnt_idx"},   32'(gnt_idx),   32'(m_last));
    check_value({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    check_value({tag, ".timeout"},   32'(timeout),   32'(m_to));
  endtask

  task automatic cycle(input string tag, input logic [3:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = 4'b0;
    done  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("rst_rel");
  endtask

  initial begin
    logic [3:0] r;
    logic       d;

    do_reset();

    // Basic grant then done, pointer moves past 0 to 2.
    cycle("b_g0", 4'b0101, 1'b0);
    check_value("b_first", 32'(gnt), 32'h1);
    cycle("b_rel", 4'b0101, 1'b1);
    check_value("b_gap", 32'(gnt), 32'h0);
    cycle("b_g2", 4'b0101, 1'b0);
    check_value("b_second", 32'(gnt), 32'h4);

    // All requesting, done each grant: 0,1,2,3,0 with idle gaps.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle("rr_g", 4'b1111, 1'b0);
      check_value("rr_order", 32'(gnt), 32'(1 << (k % 4)));
      cycle("rr_idle", 4'b1111, 1'b1);
    end

    // Request drop releases without done; search restarts at 3.
    do_reset();
    cycle("drop_g2", 4'b0100, 1'b0);
    cycle("drop_rel", 4'b0000, 1'b0);
    check_value("drop_gap", 32'(gnt), 32'h0);
    cycle("drop_g3", 4'b1001, 1'b0);
    check_value("drop_wrapsrch", 32'(gnt), 32'h8);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    cycle("ar_g1", 4'b0010, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_value("ar_gnt_async", 32'(gnt), 32'h0);
    check_outputs("ar_held");
    @(negedge clk);
    req   = 4'b0;
    rst_n = 1'b1;
    cycle("ar_regrant", 4'b0010, 1'b0);
    check_value("ar_after", 32'(gnt), 32'h2);

    // Non-granted requesters cannot preempt.
    cycle("np_hold", 4'b1111, 1'b0);
    check_value("np_same", 32'(gnt), 32'h2);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    for (int k = 0; k < TB_HOLD; k++) cycle("to_hold", 4'b0001, 1'b0);
    cycle("to_revoke", 4'b0001, 1'b0);
    check_value("to_pulse", 32'(timeout), 32'h1);
    cycle("to_regrant", 4'b0001, 1'b0);
    check_value("to_regnt", 32'(gnt), 32'h1);
    check_value("to_clear", 32'(timeout), 32'h0);
`endif

    // done in idle is ignored, then a long hold.
    do_reset();
    cycle("idle_done", 4'b0000, 1'b1);
    check_value("idle_nognt", 32'(gnt_valid), 32'h0);
    for (int k = 0; k < 300; k++) cycle("long", 4'b0001, 1'b0);
`ifndef ARB_TIMEOUT_EN
    check_value("long_gnt", 32'(gnt), 32'h1);
`endif
    cycle("long_rel", 4'b0001, 1'b1);

    // Random traffic.
    r = 4'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      d = ($urandom_range(0, 3) == 0);
      cycle("rnd", r, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arb_rr4.md
ARB_RR4 -- requirements
Module: arb_rr4

Interface
- REQ-001: Parameter HOLD_MAX, default 15, SHALL be the maximum grant duration in cycles before timeout revocation (range 1..255).
- REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  SHALL be the reset, asynchronous and active-low.
- REQ-004: req  input  4  SHALL carry the level-sensitive request per requester (bit i = requester i).
- REQ-005: done  input  1  SHALL be asserted by the granted requester for one cycle to release the grant.
- REQ-006: gnt  output  4  SHALL be the one-hot grant; all zeros when nothing is granted.
- REQ-007: gnt_idx  output  2  SHALL be the binary index of the current or most recent grantee.
- REQ-008: gnt_valid  output  1  SHALL be high exactly when gnt is non-zero.
- REQ-009: timeout  output  1  SHALL pulse high for one cycle when a grant is revoked by timeout.

Function
- REQ-010: The FSM SHALL have exactly two states: IDLE and GRANT.
- REQ-011: In IDLE with req != 0, the arbiter SHALL select the first set req bit searching upward from pointer ptr, modulo 4, and enter GRANT on the next edge.
- REQ-012: Grant latency SHALL be one cycle: a req sampled at edge N gives gnt/gnt_valid visible after edge N.
- REQ-013: In IDLE with req == 0, the arbiter SHALL remain in IDLE with gnt = 0 and ptr unchanged.
- REQ-014: gnt SHALL equal the 2-to-4 decode of gnt_idx, gated by gnt_valid.
- REQ-015: In GRANT, the arbiter SHALL release on the edge where done = 1 or req[gnt_idx] = 0, whichever comes first.
- REQ-016: On release, the arbiter SHALL return to IDLE, and ptr SHALL become gnt_idx + 1 with 2-bit wrap (3 -> 0).
- REQ-017: After every release there SHALL be exactly one IDLE cycle with gnt = 0 before the next grant.
- REQ-018: done while in IDLE SHALL be ignored.
- REQ-019: Requests from non-granted requesters SHALL neither preempt nor alter the current grant.
- REQ-020: gnt_idx SHALL hold its last value in IDLE.

Reset
- REQ-021: While rst_n = 0, state SHALL be IDLE, ptr = 0, gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0, and the hold counter SHALL be 0, independent of clk.
- REQ-022: Reset asserted mid-grant SHALL drop gnt immediately (asynchronously).
- REQ-023: After reset deassertion, the first arbitration SHALL start search at requester 0.

Configuration
- REQ-024: With macro ARB_TIMEOUT_EN defined, an 8-bit hold counter SHALL count cycles in GRANT.
- REQ-025: With ARB_TIMEOUT_EN defined, on reaching HOLD_MAX without release, the grant SHALL be revoked as in REQ-016 and timeout SHALL pulse for one cycle.
- REQ-026: With ARB_TIMEOUT_EN defined, done and timeout coinciding SHALL count as a normal release with timeout = 0.
- REQ-027: Without ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied to 0, and a grant SHALL be held indefinitely until done or request drop.

Structure
- REQ-028: Package arb_pkg SHALL hold the state enumeration (IDLE, GRANT), N_REQ = 4, and IDX_W = 2.
- REQ-029: The grant decode SHALL instantiate the team's existing decoder_2to4 sub-module (ports x, y), with output ANDed with gnt_valid.

Verification
- REQ-030: Reset, then req = 4'b0101 -> gnt = 4'b0001 one cycle later; done pulse -> one idle cycle, then gnt = 4'b0100.
- REQ-031: req = 4'b1111 held, done pulsed every grant -> grant order 0, 1, 2, 3, 0 (wrap), with one zero-gnt cycle between each grant.
- REQ-032: Requester 2 granted, req[2] dropped without done -> gnt = 0 next edge, ptr = 3; then req = 4'b1001 -> gnt = 4'b1000.
- REQ-033: rst_n pulled low mid-grant (gnt = 4'b0010) -> gnt = 0 immediately; after release with req = 4'b0010 -> gnt = 4'b0010 (search from 0).
- REQ-034: ARB_TIMEOUT_EN, HOLD_MAX = 3, req = 4'b0001 held, no done -> grant revoked after 3 grant cycles, timeout pulses once, regrant to 0 after one idle cycle.
- REQ-035: done asserted in IDLE with req = 0 -> no grant, no state change; without ARB_TIMEOUT_EN, a 300-cycle hold keeps gnt stable and timeout = 0.
